// File: rtl/r5p_div_iter.sv
// r5p_div_iter: iterative restoring radix-2 divider for RISC-V M DIV/DIVU/REM/REMU.
// One quotient bit per CALC cycle on operand magnitudes, sign fix-up on entry to DONE.
// Optional feature: define R5P_DIV_BYPASS_EN to resolve divide-by-zero and signed
// overflow directly from IDLE to DONE without iterating.
module r5p_div_iter #(
  parameter int unsigned XW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic          req_sgn,
  input  logic          req_rem,
  input  logic [XW-1:0] req_rs1,
  input  logic [XW-1:0] req_rs2,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [XW-1:0] rsp_rd,
  output logic          busy
);

  localparam int unsigned CntW = $clog2(XW);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XW-1:0]   rem_q, rem_d;      // partial remainder (always < divisor)
  logic [XW-1:0]   quo_q, quo_d;      // dividend bits shift out, quotient bits shift in
  logic [XW-1:0]   div_q, div_d;      // divisor magnitude
  logic [XW-1:0]   rsp_rd_q, rsp_rd_d;
  logic            rem_sel_q, rem_sel_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;

  // Request operand decode
  logic          rs1_neg, rs2_neg, div_zero;
  logic [XW-1:0] rs1_mag, rs2_mag;
`ifdef R5P_DIV_BYPASS_EN
  logic          sgn_ovf;
  logic [XW-1:0] bypass_rd;
`endif

  // Magnitudes and result-sign flags derived from the incoming request
  always_comb begin
    rs1_neg  = req_sgn & req_rs1[XW-1];
    rs2_neg  = req_sgn & req_rs2[XW-1];
    rs1_mag  = rs1_neg ? -req_rs1 : req_rs1;
    rs2_mag  = rs2_neg ? -req_rs2 : req_rs2;
    div_zero = (req_rs2 == '0);
`ifdef R5P_DIV_BYPASS_EN
    sgn_ovf   = req_sgn & (req_rs1 == {1'b1, {(XW-1){1'b0}}}) & (req_rs2 == '1);
    bypass_rd = div_zero ? (req_rem ? req_rs1 : '1) : (req_rem ? '0 : req_rs1);
`endif
  end

  // One restoring step: the shifted remainder is XW+1 bits wide
  logic [XW:0]   shift_w;
  logic [XW-1:0] sub_w, rem_step, quo_step, res_mag, res_fin;
  logic          sub_ok, res_neg;

  // Trial subtraction and final sign fix-up
  always_comb begin
    shift_w  = {rem_q, quo_q[XW-1]};
    sub_w    = shift_w[XW-1:0] - div_q;
    // A set top bit means the shifted value already exceeds any XW-bit divisor
    sub_ok   = shift_w[XW] | (shift_w[XW-1:0] >= div_q);
    rem_step = sub_ok ? sub_w : shift_w[XW-1:0];
    quo_step = {quo_q[XW-2:0], sub_ok};
    res_mag  = rem_sel_q ? rem_step : quo_step;
    res_neg  = rem_sel_q ? neg_rem_q : neg_quo_q;
    res_fin  = res_neg ? -res_mag : res_mag;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    rsp_rd_d  = rsp_rd_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    unique case (state_q)
      StIdle: begin
        if (req_vld) begin
          state_d   = StCalc;
          cnt_d     = CntW'(XW - 1);
          rem_d     = '0;
          quo_d     = rs1_mag;
          div_d     = rs2_mag;
          rem_sel_d = req_rem;
          // Divide by zero yields all-ones naturally from magnitudes; keep it unsigned
          neg_quo_d = (rs1_neg ^ rs2_neg) & ~div_zero;
          neg_rem_d = rs1_neg;
`ifdef R5P_DIV_BYPASS_EN
          if (div_zero || sgn_ovf) begin
            state_d  = StDone;
            cnt_d    = '0;
            rsp_rd_d = bypass_rd;
          end
`endif
        end
      end
      StCalc: begin
        rem_d = rem_step;
        quo_d = quo_step;
        if (cnt_q == '0) begin
          state_d  = StDone;
          rsp_rd_d = res_fin;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (rsp_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      rsp_rd_q  <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      rsp_rd_q  <= rsp_rd_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign req_rdy = (state_q == StIdle);
  assign rsp_vld = (state_q == StDone);
  assign busy    = (state_q != StIdle);
  assign rsp_rd  = rsp_rd_q;

endmodule

// File: tb/tb_r5p_div_iter.sv
// Testbench for r5p_div_iter (XW=32): directed vector table, backpressure and
// mid-operation reset sequences, and random operations against an arithmetic model.
module tb_r5p_div_iter;

  localparam int unsigned XW     = 32;
  localparam logic [31:0] MinInt = 32'h8000_0000;
`ifdef R5P_DIV_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_vld, req_rdy, req_sgn, req_rem;
  logic [31:0] req_rs1, req_rs2;
  logic        rsp_vld, rsp_rdy;
  logic [31:0] rsp_rd;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  r5p_div_iter #(.XW(XW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .req_sgn (req_sgn),
    .req_rem (req_rem),
    .req_rs1 (req_rs1),
    .req_rs2 (req_rs2),
    .rsp_vld (rsp_vld),
    .rsp_rdy (rsp_rdy),
    .rsp_rd  (rsp_rd),
    .busy    (busy)
  );

  typedef struct {
    bit          sgn;
    bit          rem;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // RISC-V M semantics computed with plain integer arithmetic
  function automatic logic [31:0] ref_div(input bit sgn, input bit rem,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (!sgn) return rem ? (a % b) : (a / b);
    if (a == MinInt && b == 32'hFFFF_FFFF) return rem ? 32'd0 : a;
    sa = $signed(a);
    sb = $signed(b);
    return rem ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic bit is_special(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (sgn && a == MinInt && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return MinInt;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Call right after the handshake edge; lat = edges from handshake to rsp_vld seen
  task automatic wait_rsp(output logic [31:0] res, output int lat);
    res = 'x;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (rsp_vld) begin
        lat = i;
        res = rsp_rd;
        break;
      end
    end
    if (lat < 0) check("rsp_timeout", {31'b0, rsp_vld}, 32'd1);
  endtask

  task automatic do_op(input bit sgn, input bit rem, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int lat);
    int guard;
    res = 'x;
    lat = -1;
    @(negedge clk);
    guard = 0;
    while (!req_rdy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_rdy) begin
      check("req_rdy_wait", {31'b0, req_rdy}, 32'd1);
      return;
    end
    req_vld = 1'b1;
    req_sgn = sgn;
    req_rem = rem;
    req_rs1 = a;
    req_rs2 = b;
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1;
    // Scramble operand lines while busy; the captured request must be unaffected
    req_vld = 1'b0;
    req_sgn = 1'($urandom);
    req_rem = 1'($urandom);
    req_rs1 = $urandom;
    req_rs2 = $urandom;
    wait_rsp(res, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] res, held;
    int          lat, exp_lat;
    bit          sgn, rem, seen;
    logic [31:0] a, b, exp;

    vecs.push_back('{0, 0, 32'd100,        32'd7,          32'd14});
    vecs.push_back('{1, 1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF});
    vecs.push_back('{1, 0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD});
    vecs.push_back('{1, 0, MinInt,         32'hFFFF_FFFF,  MinInt});
    vecs.push_back('{1, 1, MinInt,         32'hFFFF_FFFF,  32'd0});
    vecs.push_back('{0, 0, 32'd5,          32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{0, 1, 32'd5,          32'd0,          32'd5});
    vecs.push_back('{1, 0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{1, 1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB});
    vecs.push_back('{0, 0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF});
    vecs.push_back('{0, 1, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF});
    vecs.push_back('{1, 0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD});
    vecs.push_back('{1, 1, 32'd7,          32'hFFFF_FFFE,  32'd1});
    vecs.push_back('{0, 0, MinInt,         32'hFFFF_FFFF,  32'd0});
    vecs.push_back('{0, 1, 32'd3,          32'd10,         32'd3});

    rst_n   = 1'b0;
    req_vld = 1'b0;
    req_sgn = 1'b0;
    req_rem = 1'b0;
    req_rs1 = '0;
    req_rs2 = '0;
    rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",    {31'b0, busy},    32'd0);
    check("reset_req_rdy", {31'b0, req_rdy}, 32'd1);
    check("reset_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    check("reset_rsp_rd",  rsp_rd,           32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].sgn, vecs[i].rem, vecs[i].a, vecs[i].b, res, lat);
      exp_lat = (Bypass && is_special(vecs[i].sgn, vecs[i].a, vecs[i].b)) ? 1 : XW + 1;
      check($sformatf("vec%0d_rd", i), res, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat));
    end

    // Backpressure: result held while rsp_rdy low, pending request not taken early
    @(negedge clk);
    req_vld = 1'b1;
    req_sgn = 1'b0;
    req_rem = 1'b0;
    req_rs1 = 32'd1000;
    req_rs2 = 32'd10;
    rsp_rdy = 1'b0;
    @(posedge clk);
    #1;
    req_rs1 = 32'd77;
    req_rs2 = 32'd7;
    wait_rsp(held, lat);
    check("bp_rd", held, 32'd100);
    check("bp_lat", 32'(lat), 32'(XW + 1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_vld", i), {31'b0, rsp_vld}, 32'd1);
      check($sformatf("bp_hold%0d_rd", i), rsp_rd, 32'd100);
      check($sformatf("bp_hold%0d_rdy", i), {31'b0, req_rdy}, 32'd0);
    end
    rsp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_gap_req_rdy", {31'b0, req_rdy}, 32'd1);
    check("bp_gap_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    check("bp_gap_busy",    {31'b0, busy},    32'd0);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    wait_rsp(res, lat);
    check("bp_next_rd", res, 32'd11);
    check("bp_next_lat", 32'(lat), 32'(XW + 1));

    // Reset at iteration 15 drops the operation without a response
    @(negedge clk);
    req_vld = 1'b1;
    req_sgn = 1'b0;
    req_rem = 1'b0;
    req_rs1 = 32'hFFFF_FFFF;
    req_rs2 = 32'd3;
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy",    {31'b0, busy},    32'd0);
    check("abort_req_rdy", {31'b0, req_rdy}, 32'd1);
    check("abort_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    check("abort_rsp_rd",  rsp_rd,           32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_vld) seen = 1'b1;
    end
    check("abort_no_rsp", {31'b0, seen}, 32'd0);
    do_op(1'b0, 1'b0, 32'd9, 32'd3, res, lat);
    check("after_abort_rd", res, 32'd3);
    check("after_abort_lat", 32'(lat), 32'(XW + 1));

    // Random operations against the arithmetic model
    for (int i = 0; i < 250; i++) begin
      sgn = 1'($urandom);
      rem = 1'($urandom);
      a   = pick();
      b   = pick();
      exp = ref_div(sgn, rem, a, b);
      exp_lat = (Bypass && is_special(sgn, a, b)) ? 1 : XW + 1;
      do_op(sgn, rem, a, b, res, lat);
      check($sformatf("rnd%0d_rd sgn=%0d rem=%0d a=%h b=%h", i, sgn, rem, a, b), res, exp);
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
